// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one Data_Memory port between two cache controllers.
// Optional memory-handshake watchdog is compiled in with MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req0_enable_i,
    input  logic              req0_write_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ack_o,
    output logic [DATA_W-1:0] req0_data_o,
    output logic              req0_err_o,
    input  logic              req1_enable_i,
    input  logic              req1_write_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ack_o,
    output logic [DATA_W-1:0] req1_data_o,
    output logic              req1_err_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              last_q;
    logic              grant_q;
    logic              take;
    logic              pick;
    logic              req0_v;
    logic              req1_v;
    logic              wd_hit;
    logic              to_q;
    logic [DATA_W-1:0] resp_line;

    // A port whose ack is on the wire still holds enable for this edge;
    // it must not be granted again off that stale request.
    assign req0_v = req0_enable_i & ~req0_ack_o;
    assign req1_v = req1_enable_i & ~req1_ack_o;

    // Next-state and grant selection (tie goes to the port not served last)
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        pick    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0_v || req1_v) begin
                    take    = 1'b1;
                    state_d = BUSY;
                    pick    = (req0_v && req1_v) ? ~last_q : req1_v;
                end
            end
            BUSY: begin
                if (mem_ack_i || wd_hit) begin
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory-side request: latched on grant, held through BUSY
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            grant_q      <= 1'b0;
            last_q       <= 1'b1;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else if (take) begin
            grant_q      <= pick;
            last_q       <= pick;
            mem_enable_o <= 1'b1;
            mem_write_o  <= pick ? req1_write_i : req0_write_i;
            mem_addr_o   <= pick ? req1_addr_i : req0_addr_i;
            mem_data_o   <= pick ? req1_data_i : req0_data_i;
        end else if (state_q == BUSY && state_d == RESP) begin
            mem_enable_o <= 1'b0;
        end
    end

    // Line handed back: zeros on timeout, the write line on writes
    assign resp_line = to_q ? '0 : (mem_write_o ? mem_data_o : mem_data_i);

    // Requester-side ack pulse and sticky read line
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req0_ack_o  <= 1'b0;
            req1_ack_o  <= 1'b0;
            req0_data_o <= '0;
            req1_data_o <= '0;
        end else begin
            req0_ack_o <= (state_q == RESP) && !grant_q;
            req1_ack_o <= (state_q == RESP) && grant_q;
            if (state_q == RESP && !grant_q) begin
                req0_data_o <= resp_line;
            end
            if (state_q == RESP && grant_q) begin
                req1_data_o <= resp_line;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q;

    // A same-cycle mem_ack_i wins over the watchdog
    assign wd_hit = (state_q == BUSY) && !mem_ack_i
                  && (wd_q == WD_W'(TIMEOUT));

    // Watchdog: counts BUSY cycles from grant, flags an abandoned access
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else if (take) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else if (wd_hit) begin
            to_q <= 1'b1;
        end else if (state_q == BUSY) begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    // Error flag travels with the ack pulse
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req0_err_o <= 1'b0;
            req1_err_o <= 1'b0;
        end else begin
            req0_err_o <= (state_q == RESP) && !grant_q && to_q;
            req1_err_o <= (state_q == RESP) && grant_q && to_q;
        end
    end
`else
    // No watchdog: BUSY waits for mem_ack_i indefinitely.
    // A negative TIMEOUT is meaningless, so this term is always 0.
    assign wd_hit     = 1'b0;
    assign to_q       = (TIMEOUT < 0);
    assign req0_err_o = 1'b0;
    assign req1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural memory.
// Timeout scenario runs only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 256;
    localparam int TO = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic          clk_i;
    logic          rst_n_i;
    logic          req0_enable_i;
    logic          req0_write_i;
    logic [AW-1:0] req0_addr_i;
    logic [DW-1:0] req0_data_i;
    logic          req0_ack_o;
    logic [DW-1:0] req0_data_o;
    logic          req0_err_o;
    logic          req1_enable_i;
    logic          req1_write_i;
    logic [AW-1:0] req1_addr_i;
    logic [DW-1:0] req1_data_i;
    logic          req1_ack_o;
    logic [DW-1:0] req1_data_o;
    logic          req1_err_o;
    logic          mem_enable_o;
    logic          mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_data_i;

    mem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .req0_enable_i(req0_enable_i),
        .req0_write_i(req0_write_i),
        .req0_addr_i(req0_addr_i),
        .req0_data_i(req0_data_i),
        .req0_ack_o(req0_ack_o),
        .req0_data_o(req0_data_o),
        .req0_err_o(req0_err_o),
        .req1_enable_i(req1_enable_i),
        .req1_write_i(req1_write_i),
        .req1_addr_i(req1_addr_i),
        .req1_data_i(req1_data_i),
        .req1_ack_o(req1_ack_o),
        .req1_data_o(req1_data_o),
        .req1_err_o(req1_err_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i),
        .mem_data_i(mem_data_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;
    exp_t eq0[$];
    exp_t eq1[$];
    int tq0[$];
    int tq1[$];
    int glog[$];
    int gcyc[$];
    logic [DW-1:0] model_mem [logic [AW-1:0]];
    logic [DW-1:0] mem_store [logic [AW-1:0]];
    bit mute = 1'b0;
    int lat_fixed = 0;
    int epoch = 0;

    function automatic logic [DW-1:0] init_line(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        logic [31:0] w;
        if (a == 32'h60) begin
            v = {32{8'hA5}};
        end else begin
            for (int i = 0; i < DW / 32; i++) begin
                w = (a * 32'h9E3779B1) ^ (i * 32'h85EBCA6B) ^ 32'h5A5A0F0F;
                v[i*32 +: 32] = w;
            end
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Which requester owns the access now on the memory port
    function automatic int owner(input logic [AW-1:0] a);
        bit m0;
        bit m1;
        m0 = (eq0.size() > 0) && (eq0[0].addr == a);
        m1 = (eq1.size() > 0) && (eq1[0].addr == a);
        if (m0 && !m1) return 0;
        if (m1 && !m0) return 1;
        return -1;
    endfunction

    task automatic issue(input int p, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit to, output int ack_at);
        exp_t e;
        int n;
        e.addr = a;
        e.wr   = wr;
        e.err  = to;
        if (to) begin
            e.data = '0;
        end else if (wr) begin
            e.data = d;
            model_mem[a] = d;
        end else begin
            e.data = model_mem[a];
        end
        if (p == 0) begin
            eq0.push_back(e);
            req0_write_i = wr; req0_addr_i = a; req0_data_i = d;
            req0_enable_i = 1'b1;
        end else begin
            eq1.push_back(e);
            req1_write_i = wr; req1_addr_i = a; req1_data_i = d;
            req1_enable_i = 1'b1;
        end
        n = 0;
        ack_at = -1;
        while (ack_at < 0 && n < 400) begin
            @(posedge clk_i); #1;
            n++;
            if ((p == 0) ? req0_ack_o : req1_ack_o) ack_at = cyc;
        end
        if (ack_at < 0) fail_now($sformatf("req%0d_no_ack", p));
        @(posedge clk_i); #1;
        if (p == 0) req0_enable_i = 1'b0;
        else req1_enable_i = 1'b0;
    endtask

    task automatic check_ack(input int p);
        exp_t e;
        int t;
        if ((p == 0 && eq0.size() == 0) || (p == 1 && eq1.size() == 0)) begin
            fail_now($sformatf("unexpected_ack%0d", p));
            return;
        end
        if (p == 0) e = eq0.pop_front();
        else e = eq1.pop_front();
        chk($sformatf("ack%0d_data", p), (p == 0) ? req0_data_o : req1_data_o, e.data);
        chk($sformatf("ack%0d_err", p), (p == 0) ? req0_err_o : req1_err_o, e.err);
        if (e.err) chk("to_mem_en_low", mem_enable_o, 1'b0);
        if ((p == 0 && tq0.size() == 0) || (p == 1 && tq1.size() == 0)) begin
            fail_now($sformatf("ack%0d_time_missing", p));
        end else begin
            t = (p == 0) ? tq0.pop_front() : tq1.pop_front();
            chk($sformatf("ack%0d_cycle", p), cyc, t);
        end
    endtask

    // Monitor: compares every ack against the scoreboard
    initial begin
        forever begin
            @(posedge clk_i); #1;
            if (rst_n_i) begin
                if (req0_ack_o && req1_ack_o) fail_now("dual_ack");
                if (req0_ack_o) check_ack(0);
                if (req1_ack_o) check_ack(1);
            end
        end
    end

    // Behavioural Data_Memory: ack lat+1 edges after it first sees enable
    initial begin
        int g, ep, p, lat, k;
        logic [AW-1:0] a;
        logic w;
        logic [DW-1:0] d;
        exp_t e;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        for (int i = 0; i < 8; i++) begin
            mem_store[32'(i * 32)] = init_line(32'(i * 32));
            mem_store[32'(256 + i * 32)] = init_line(32'(256 + i * 32));
        end
        forever begin
            @(posedge clk_i); #1;
            if (rst_n_i && mem_enable_o) begin
                g = cyc; ep = epoch;
                a = mem_addr_o; w = mem_write_o; d = mem_data_o;
                p = owner(a);
                if (p < 0) begin
                    fail_now("spurious_grant");
                end else begin
                    glog.push_back(p);
                    gcyc.push_back(g);
                    e = (p == 0) ? eq0[0] : eq1[0];
                    chk("grant_write", w, e.wr);
                    if (w) chk("grant_wdata", d, e.data);
                end
                if (mute) begin
                    if (p == 0) tq0.push_back(g + TO + 2);
                    if (p == 1) tq1.push_back(g + TO + 2);
                    k = 0;
                    while (mem_enable_o && k < 100) begin
                        @(posedge clk_i); #1;
                        k++;
                    end
                    if (mem_enable_o) fail_now("timeout_no_drop");
                end else begin
                    lat = (lat_fixed > 0) ? lat_fixed : $urandom_range(1, 6);
                    repeat (lat + 1) @(posedge clk_i);
                    #1;
                    if (ep == epoch) begin
                        chk("mem_hold_addr", mem_addr_o, a);
                        chk("mem_hold_en", mem_enable_o, 1'b1);
                    end
                    mem_ack_i = 1'b1;
                    @(posedge clk_i); #1;
                    mem_ack_i = 1'b0;
                    if (w) begin
                        mem_store[a] = d;
                        mem_data_i = ~d;
                    end else begin
                        mem_data_i = mem_store[a];
                    end
                    if (ep == epoch && p == 0) tq0.push_back(g + lat + 3);
                    if (ep == epoch && p == 1) tq1.push_back(g + lat + 3);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    // Stimulus
    initial begin
        int t0, t1, t2, s, n;
        int order[4];
        exp_t e;
        order = '{0, 1, 0, 1};
        rst_n_i = 1'b0;
        req0_enable_i = 1'b0; req0_write_i = 1'b0; req0_addr_i = '0; req0_data_i = '0;
        req1_enable_i = 1'b0; req1_write_i = 1'b0; req1_addr_i = '0; req1_data_i = '0;
        for (int i = 0; i < 8; i++) begin
            model_mem[32'(i * 32)] = init_line(32'(i * 32));
            model_mem[32'(256 + i * 32)] = init_line(32'(256 + i * 32));
        end
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_mem_en", mem_enable_o, 1'b0);
        chk("rst_mem_wr", mem_write_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, '0);
        chk("rst_mem_data", mem_data_o, '0);
        chk("rst_ack0", req0_ack_o, 1'b0);
        chk("rst_ack1", req1_ack_o, 1'b0);
        chk("rst_data0", req0_data_o, '0);
        chk("rst_data1", req1_data_o, '0);
        chk("rst_err0", req0_err_o, 1'b0);
        chk("rst_err1", req1_err_o, 1'b0);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // Both ports requesting from reset, re-raising at once
        glog.delete();
        fork
            begin
                issue(0, 1'b0, 32'h000, '0, 1'b0, t0);
                issue(0, 1'b0, 32'h020, '0, 1'b0, t0);
            end
            begin
                issue(1, 1'b0, 32'h100, '0, 1'b0, t1);
                issue(1, 1'b0, 32'h120, '0, 1'b0, t1);
            end
        join
        chk("grant_count", glog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < glog.size()) chk($sformatf("grant_order_%0d", i), glog[i], order[i]);
        end

        // Single read with a 9-cycle memory
        lat_fixed = 9;
        s = cyc;
        issue(0, 1'b0, 32'h60, '0, 1'b0, t0);
        chk("read_ack_latency", t0, s + 13);
        chk("read_grant_cycle", gcyc[$], s + 1);
        lat_fixed = 0;

        // Write then read back on port 1
        issue(1, 1'b1, 32'h20, 256'h1234, 1'b0, t1);
        issue(1, 1'b0, 32'h20, '0, 1'b0, t1);

        // Back-to-back on port 0: re-raised the cycle after ack
        issue(0, 1'b0, 32'h40, '0, 1'b0, t0);
        issue(0, 1'b1, 32'h80, rand_line(), 1'b0, t2);
        chk("b2b_regrant", gcyc[$], t0 + 2);

        // Reset while the memory access is outstanding
        lat_fixed = 9;
        e.addr = 32'h40; e.wr = 1'b0; e.data = model_mem[32'h40]; e.err = 1'b0;
        eq0.push_back(e);
        req0_write_i = 1'b0; req0_addr_i = 32'h40; req0_data_i = '0;
        req0_enable_i = 1'b1;
        n = 0;
        while (!mem_enable_o && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!mem_enable_o) fail_now("busy_rst_no_grant");
        repeat (4) @(posedge clk_i);
        #1;
        epoch++;
        rst_n_i = 1'b0;
        #1;
        chk("busy_rst_mem_en", mem_enable_o, 1'b0);
        chk("busy_rst_mem_addr", mem_addr_o, '0);
        chk("busy_rst_mem_data", mem_data_o, '0);
        chk("busy_rst_data0", req0_data_o, '0);
        chk("busy_rst_data1", req1_data_o, '0);
        chk("busy_rst_ack0", req0_ack_o, 1'b0);
        eq0.delete();
        req0_enable_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        repeat (20) @(posedge clk_i);
        #1;
        issue(0, 1'b0, 32'h60, '0, 1'b0, t0);
        lat_fixed = 0;

`ifdef MEM_ARB_TIMEOUT_EN
        mute = 1'b1;
        issue(1, 1'b0, 32'h140, '0, 1'b1, t1);
        mute = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
`endif

        // Random traffic, disjoint address regions per port
        fork
            begin
                for (int i = 0; i < 15; i++) begin
                    issue(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7) * 32),
                          rand_line(), 1'b0, t0);
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk_i); #1;
                    end
                end
            end
            begin
                for (int i = 0; i < 15; i++) begin
                    issue(1, 1'($urandom_range(0, 1)), 32'(256 + $urandom_range(0, 7) * 32),
                          rand_line(), 1'b0, t1);
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk_i); #1;
                    end
                end
            end
        join

        repeat (5) @(posedge clk_i);
        #1;
        chk("eq0_drained", eq0.size(), 0);
        chk("eq1_drained", eq1.size(), 0);
        chk("tq0_drained", tq0.size(), 0);
        chk("tq1_drained", tq1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
